// File: rtl/ex_mem_stage_pkg.sv
// Shared pipeline defines: polarity constants, default bus widths and the
// one-hot stage-control encoding used by every pipeline register.
package ex_mem_stage_pkg;

    localparam logic RstEnable = 1'b0;
    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;

    localparam int unsigned RegBus       = 32;
    localparam int unsigned AluOpBus     = 8;
    localparam int unsigned DoubleRegBus = 64;

    localparam logic [4:0]        NOPRegAddr = 5'd0;
    localparam logic [RegBus-1:0] ZeroWord   = '0;

    // One-hot {rst, flush, bubble, advance, hold}
    typedef enum logic [4:0] {
        CTL_HOLD    = 5'b00001,
        CTL_ADVANCE = 5'b00010,
        CTL_BUBBLE  = 5'b00100,
        CTL_FLUSH   = 5'b01000,
        CTL_RST     = 5'b10000
    } stage_ctl_e;

endpackage

// File: rtl/ex_mem_stage_pipe_stall_ctl.sv
// Stage-control decode for a pipeline register: picks one action per edge.
// Purely combinational; priority reset > flush > bubble > advance > hold.
// Backpressure: stall_next_i high while this stage stalls means hold, not bubble.
module pipe_stall_ctl
    import ex_mem_stage_pkg::*;
(
    input  logic       rst_i,
    input  logic       flush_i,
    input  logic       stall_self_i,
    input  logic       stall_next_i,
    output logic [4:0] ctl_o
);

    always_comb begin
        ctl_o = CTL_HOLD;
        if (rst_i == RstEnable) begin
            ctl_o = CTL_RST;
        end else if (flush_i) begin
            ctl_o = CTL_FLUSH;
        end else if (stall_self_i == NoStop) begin
            ctl_o = CTL_ADVANCE;
        end else if (stall_next_i == NoStop) begin
            ctl_o = CTL_BUBBLE;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid, payload and multi-cycle scratch loop to EX.
// Latency 1 cycle, registered outputs only; optional counter via EX_MEM_STALL_CNT_EN.
// Backpressure: stall vector holds (MEM stalled) or inserts a bubble (only EX stalled).
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W   = RegBus,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ALUOP_W  = AluOpBus,
    parameter int unsigned CARRY_W  = DoubleRegBus,
    parameter int unsigned CNT_W    = 2,
    parameter int unsigned STALL_W  = 6,
    parameter int unsigned STAGE    = 3,
    parameter int unsigned NOP_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               ex_valid,
    input  logic [ADDR_W-1:0]  ex_wd,
    input  logic               ex_wreg,
    input  logic [DATA_W-1:0]  ex_wdata,
    input  logic [DATA_W-1:0]  ex_hi,
    input  logic [DATA_W-1:0]  ex_lo,
    input  logic               ex_whilo,
    input  logic [ALUOP_W-1:0] ex_aluop,
    input  logic [DATA_W-1:0]  ex_reg2,
    input  logic [DATA_W-1:0]  ex_mem_addr,
    input  logic [CARRY_W-1:0] carry_i,
    input  logic [CNT_W-1:0]   cnt_i,
    output logic               mem_valid,
    output logic [ADDR_W-1:0]  mem_wd,
    output logic               mem_wreg,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [DATA_W-1:0]  mem_hi,
    output logic [DATA_W-1:0]  mem_lo,
    output logic               mem_whilo,
    output logic [ALUOP_W-1:0] mem_aluop,
    output logic [DATA_W-1:0]  mem_reg2,
    output logic [DATA_W-1:0]  mem_mem_addr,
    output logic [CARRY_W-1:0] carry_o,
    output logic [CNT_W-1:0]   cnt_o,
    output logic [15:0]        stall_cnt
);

    typedef struct packed {
        logic               valid;
        logic [ADDR_W-1:0]  wd;
        logic               wreg;
        logic [DATA_W-1:0]  wdata;
        logic [DATA_W-1:0]  hi;
        logic [DATA_W-1:0]  lo;
        logic               whilo;
        logic [ALUOP_W-1:0] aluop;
        logic [DATA_W-1:0]  reg2;
        logic [DATA_W-1:0]  mem_addr;
    } payload_t;

    payload_t           pl_q, pl_d, ex_pl, bubble_pl;
    logic [CARRY_W-1:0] carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         ctl;

    // Only this stage's bit and the downstream bit matter (STAGE < STALL_W-1).
    logic unused_stall;
    assign unused_stall = ^stall;

    pipe_stall_ctl u_ctl (
        .rst_i        (rst),
        .flush_i      (flush),
        .stall_self_i (stall[STAGE]),
        .stall_next_i (stall[STAGE+1]),
        .ctl_o        (ctl)
    );

    always_comb begin
        bubble_pl    = '0;
        bubble_pl.wd = ADDR_W'(NOP_ADDR);

        ex_pl          = '0;
        ex_pl.valid    = ex_valid;
        ex_pl.wd       = ex_wd;
        ex_pl.wreg     = ex_wreg;
        ex_pl.wdata    = ex_wdata;
        ex_pl.hi       = ex_hi;
        ex_pl.lo       = ex_lo;
        ex_pl.whilo    = ex_whilo;
        ex_pl.aluop    = ex_aluop;
        ex_pl.reg2     = ex_reg2;
        ex_pl.mem_addr = ex_mem_addr;

        pl_d    = pl_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (ctl)
            CTL_RST, CTL_FLUSH: begin
                // Clearing the scratch channel aborts any multi-cycle op in EX.
                pl_d    = bubble_pl;
                carry_d = '0;
                cnt_d   = '0;
            end
            CTL_BUBBLE: begin
                // EX is iterating: loop its partial result back unchanged.
                pl_d    = bubble_pl;
                carry_d = carry_i;
                cnt_d   = cnt_i;
            end
            CTL_ADVANCE: begin
                pl_d    = ex_pl;
                carry_d = '0;
                cnt_d   = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pl_q    <= bubble_pl;
            carry_q <= '0;
            cnt_q   <= '0;
        end else begin
            pl_q    <= pl_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_valid    = pl_q.valid;
    assign mem_wd       = pl_q.wd;
    assign mem_wreg     = pl_q.wreg;
    assign mem_wdata    = pl_q.wdata;
    assign mem_hi       = pl_q.hi;
    assign mem_lo       = pl_q.lo;
    assign mem_whilo    = pl_q.whilo;
    assign mem_aluop    = pl_q.aluop;
    assign mem_reg2     = pl_q.reg2;
    assign mem_mem_addr = pl_q.mem_addr;
    assign carry_o      = carry_q;
    assign cnt_o        = cnt_q;

`ifdef EX_MEM_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Counts stalled edges regardless of flush; saturates rather than wraps.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall[STAGE] == Stop && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Parametrised EX/MEM pipeline register for the 5-stage core, sitting between the execute stage and the memory stage.
- Carries the full write-back, HI/LO and load/store payload, with a valid bit.
- Handles stall-vector hold and bubble insertion, plus a new flush input.
- Carries a generalised multi-cycle scratch channel (CARRY_W bits, CNT_W-bit step counter) back to EX while EX iterates.

Parameters:
- DATA_W, 32, width of data/HI/LO/reg2/mem_addr fields
- ADDR_W, 5, register-file address width
- ALUOP_W, 8, ALU opcode width
- CARRY_W, 64, multi-cycle scratch width (HI:LO accumulator for madd/msub/div)
- CNT_W, 2, multi-cycle step-counter width
- STALL_W, 6, stall vector width
- STAGE, 3, index of this stage's own bit in the stall vector; STAGE+1 is the downstream (MEM) bit; must be less than STALL_W-1
- NOP_ADDR, 0, register address driven on bubble/reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-low reset (0 = reset)
- stall  in  STALL_W  stall vector from control; 1 = stop
- flush  in  1  kill the EX instruction (exception/eret)
- ex_valid  in  1  EX holds a real instruction
- ex_wd  in  ADDR_W  destination register
- ex_wreg  in  1  register write enable
- ex_wdata  in  DATA_W  result
- ex_hi, ex_lo  in  DATA_W  HI/LO values
- ex_whilo  in  1  HI/LO write enable
- ex_aluop  in  ALUOP_W  load/store opcode
- ex_reg2  in  DATA_W  store data / original rt value
- ex_mem_addr  in  DATA_W  load/store address
- carry_i  in  CARRY_W  multi-cycle partial result from EX
- cnt_i  in  CNT_W  multi-cycle step from EX
- mem_valid  out  1  registered ex_valid
- mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop, mem_reg2, mem_mem_addr  out  as inputs  registered payload
- carry_o  out  CARRY_W  scratch returned to EX
- cnt_o  out  CNT_W  step returned to EX
- stall_cnt  out  16  stall-cycle counter (optional feature)

Behaviour:
- All updates happen on the rising clk edge. Latency is 1 cycle. No combinational path from input to output.
- Priority per edge: reset > flush > bubble > advance > hold.
- Reset (rst==0):
  - Every output is driven to 0.
  - mem_wd is driven to NOP_ADDR.
  - mem_aluop is driven to 0 (NOP op).
- Flush (flush==1, not in reset):
  - Payload becomes a bubble, as defined below.
  - carry_o and cnt_o are cleared to 0; this aborts any multi-cycle operation.
  - Flush wins over every stall combination.
- Bubble (stall[STAGE]==1 and stall[STAGE+1]==0):
  - mem_valid=0, mem_wreg=0, mem_whilo=0, mem_wd=NOP_ADDR.
  - All data fields and mem_aluop are set to 0.
  - carry_o<=carry_i and cnt_o<=cnt_i, so EX resumes its iteration next cycle.
- Advance (stall[STAGE]==0):
  - Every mem_* field, including mem_aluop, mem_reg2 and mem_mem_addr, takes the matching ex_* value.
  - mem_valid<=ex_valid.
  - carry_o and cnt_o are cleared to 0.
- Hold (stall[STAGE]==1 and stall[STAGE+1]==1): every output register keeps its value, including carry_o and cnt_o.
- Bits of stall other than STAGE and STAGE+1 are ignored.
- Reset asserted mid multi-cycle operation: carry_o and cnt_o are cleared on the same edge.

Optional Feature:
- Macro: EX_MEM_STALL_CNT_EN.
- When defined:
  - stall_cnt is a 16-bit counter that increments on every non-reset edge where stall[STAGE]==1.
  - The counter saturates at 16'hFFFF.
  - Reset clears it; flush does not.
- When undefined: stall_cnt is tied to 0 and no counter flops are instantiated.

Decomposition:
- Shared defines package:
  - reset and stall polarity constants (RstEnable=0, Stop=1, NoStop=0)
  - NOPRegAddr, ZeroWord
  - default widths (RegBus, AluOpBus, DoubleRegBus)
- The stage-control decode is one natural sub-module: pipe_stall_ctl.
  - Inputs: rst, flush, stall[STAGE], stall[STAGE+1].
  - Output: a one-hot {rst, flush, bubble, advance, hold}.
  - Reusable by the IF/ID, ID/EX and MEM/WB registers.
- The datapath stays in ex_mem_stage.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random ex_* values -> every output is 0 and mem_wd=0. Release rst with stall=0 and ex_wdata=32'hDEADBEEF -> mem_wdata=32'hDEADBEEF and mem_valid=1 one edge later.
- Load/store advance: ex_aluop=8'hA3, ex_mem_addr=32'h00001004, ex_reg2=32'h12345678, stall=0 -> next cycle mem_aluop=8'hA3, mem_mem_addr=32'h00001004, mem_reg2=32'h12345678.
- Multi-cycle bubble: stall=6'b001000, carry_i=64'h1_0000_0002, cnt_i=2'b01 -> mem_wreg=0, mem_valid=0, carry_o=64'h1_0000_0002, cnt_o=1. Then stall=0 -> carry_o=0, cnt_o=0, and the payload advances.
- Hold: preload mem_wdata=32'h55, then stall=6'b011000 for 3 cycles with changing inputs -> all outputs stay constant, including carry_o and cnt_o.
- Flush priority: stall=6'b001000, cnt_i=2, flush=1 -> cnt_o=0, carry_o=0, mem_valid=0.
- EX_MEM_STALL_CNT_EN defined: 5 cycles with stall[3]=1, then 1 flush -> stall_cnt=5; saturation forced at 16'hFFFF stays 16'hFFFF.
